// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC generator, one-outstanding imem fetch, DEPTH-entry prefetch FIFO.
// Ports: clk/rst_n, imem_* fetch bus, redirect_*/status events, id_* head handshake. Macro: IF_KEEP_KERNEL_BIT_EN.
module if_fetch_queue #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_0000,
   parameter logic [ADDR_W-1:0] INTR_VEC = 32'h8000_0004,
   parameter logic [ADDR_W-1:0] EXC_VEC = 32'h8000_0008
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   input  logic [1:0]        status,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc_plus4
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] req_tag;
   logic [ADDR_W-1:0] evt_pc;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              pending;
   logic              discard;
   logic              evt;
   logic              resp;
   logic              push;
   logic              pop;

   logic [31:0]       q_instr [DEPTH];
   logic [ADDR_W-1:0] q_tag [DEPTH];

   function automatic logic [ADDR_W-1:0] inc4(
      input logic [ADDR_W-1:0] a
   );
`ifdef IF_KEEP_KERNEL_BIT_EN
      inc4 = {a[ADDR_W-1], a[ADDR_W-2:0] + (ADDR_W-1)'(4)};
`else
      inc4 = a + ADDR_W'(4);
`endif
   endfunction

   assign pc_inc = inc4(pc);
   assign evt = redirect_valid | (|status);

   // Both status bits may be set: the interrupt takes precedence,
   // so a priority (not unique) decode is required here.
   always_comb begin
      evt_pc = redirect_target;
      priority case (1'b1)
         status[1]: evt_pc = INTR_VEC;
         status[0]: evt_pc = EXC_VEC;
         default:   evt_pc = redirect_target;
      endcase
   end

   // A response only counts against an outstanding request; a strobe
   // seen with nothing pending (e.g. across a reset) is ignored.
   assign resp = imem_valid & pending;
   assign push = resp & ~discard & ~evt;
   assign pop  = id_valid & id_ready & ~evt;

   // Occupancy including the in-flight slot, net of this cycle's pop.
   assign occ = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);

   assign imem_req = rst_n & ~evt
                   & (~pending | imem_valid)
                   & (occ < (CW+1)'(DEPTH));
   assign imem_addr = pc;

   assign id_valid    = (count != '0);
   assign id_instr    = q_instr[rd_ptr];
   assign id_pc_plus4 = q_tag[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_VEC;
         req_tag <= '0;
         pending <= 1'b0;
         discard <= 1'b0;
      end else if (evt) begin
         pc <= evt_pc;
         // A still-outstanding fetch belongs to the old stream; its
         // response must be swallowed when it finally arrives.
         if (pending & ~imem_valid) begin
            discard <= 1'b1;
         end else begin
            pending <= 1'b0;
            discard <= 1'b0;
         end
      end else begin
         if (imem_req) begin
            pc      <= pc_inc;
            req_tag <= pc_inc;
            pending <= 1'b1;
         end else if (resp) begin
            pending <= 1'b0;
         end
         if (resp) begin
            discard <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (evt) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_instr[i] <= '0;
            q_tag[i]   <= '0;
         end
      end else if (push) begin
         q_instr[wr_ptr] <= imem_rdata;
         q_tag[wr_ptr]   <= req_tag;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue with a latency-programmable memory.
// Honours IF_KEEP_KERNEL_BIT_EN for the PC wrap expectation.
module tb_if_fetch_queue;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [1:0]  status;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc_plus4;

`ifdef IF_KEEP_KERNEL_BIT_EN
   localparam logic [31:0] WRAP = 32'h8000_0000;
`else
   localparam logic [31:0] WRAP = 32'h0000_0000;
`endif

   typedef struct {
      int          due;
      logic [31:0] addr;
   } mreq_t;

   mreq_t       mq [$];
   int          lat;
   int          cyc_n;
   int          nreq;
   int          nvec;
   int          nerr;
   logic        req_q;
   logic [31:0] addr_q;

   if_fetch_queue dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_valid      (imem_valid),
      .imem_rdata      (imem_rdata),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .status          (status),
      .id_valid        (id_valid),
      .id_ready        (id_ready),
      .id_instr        (id_instr),
      .id_pc_plus4     (id_pc_plus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      word = a ^ 32'h5A5A_A5A5;
   endfunction

   always @(negedge clk) begin
      req_q  = imem_req;
      addr_q = imem_addr;
   end

   initial begin
      mreq_t m;
      imem_valid = 1'b0;
      imem_rdata = '0;
      cyc_n = 0;
      forever begin
         @(posedge clk);
         #1;
         cyc_n++;
         imem_valid = 1'b0;
         if (req_q) begin
            m.due  = cyc_n + lat - 1;
            m.addr = addr_q;
            mq.push_back(m);
            nreq++;
         end
         if (mq.size() > 0) begin
            if (mq[0].due == cyc_n) begin
               imem_valid = 1'b1;
               imem_rdata = word(mq[0].addr);
               void'(mq.pop_front());
            end
         end
      end
   end

   task automatic nx();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      nx();
      rst_n = 1'b0;
      mq.delete();
      nreq = 0;
      nx();
      nx();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      id_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_target = '0;
      status = 2'b00;
      lat = 1;
      nreq = 0;
      nvec = 0;
      nerr = 0;
      req_q = 1'b0;
      addr_q = '0;

      // reset values
      nx();
      #1;
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_id_instr", id_instr, 32'd0);
      chk("rst_id_pc4", id_pc_plus4, 32'd0);

      // streaming with 1-cycle memory
      do_reset();
      #1;
      chk("c0_req", 32'(imem_req), 32'd1);
      chk("c0_addr", imem_addr, 32'h8000_0000);
      chk("c0_id_valid", 32'(id_valid), 32'd0);
      nx();
      #1;
      chk("c1_id_valid", 32'(id_valid), 32'd0);
      chk("c1_addr", imem_addr, 32'h8000_0004);
      nx();
      #1;
      chk("c2_id_valid", 32'(id_valid), 32'd1);
      chk("c2_instr", id_instr, word(32'h8000_0000));
      chk("c2_pc4", id_pc_plus4, 32'h8000_0004);
      nx();
      #1;
      chk("c3_pc4", id_pc_plus4, 32'h8000_0008);
      chk("c3_instr", id_instr, word(32'h8000_0004));
      nx();
      #1;
      chk("c4_pc4", id_pc_plus4, 32'h8000_000C);

      // back-pressure: queue fills, exactly DEPTH requests
      id_ready = 1'b0;
      do_reset();
      repeat (10) nx();
      #1;
      chk("full_nreq", 32'(nreq), 32'd4);
      chk("full_req", 32'(imem_req), 32'd0);
      chk("full_addr", imem_addr, 32'h8000_0010);
      chk("full_pc4", id_pc_plus4, 32'h8000_0004);
      id_ready = 1'b1;
      #1;
      chk("resume_req", 32'(imem_req), 32'd1);
      for (int i = 0; i < 5; i++) begin
         nx();
         #1;
         chk("resume_valid", 32'(id_valid), 32'd1);
         chk("resume_pc4", id_pc_plus4, 32'h8000_0008 + 32'(4 * i));
      end

      // 3-cycle memory, redirect with a fetch in flight
      lat = 3;
      do_reset();
      nx();
      redirect_valid = 1'b1;
      redirect_target = 32'h8000_0100;
      #1;
      chk("redir_req", 32'(imem_req), 32'd0);
      nx();
      redirect_valid = 1'b0;
      #1;
      chk("stale_wait_req", 32'(imem_req), 32'd0);
      chk("stale_wait_valid", 32'(id_valid), 32'd0);
      nx();
      #1;
      chk("stale_drop_req", 32'(imem_req), 32'd1);
      chk("stale_drop_addr", imem_addr, 32'h8000_0100);
      nx();
      #1;
      chk("stale_not_pushed", 32'(id_valid), 32'd0);
      nx();
      nx();
      nx();
      #1;
      chk("redir_valid", 32'(id_valid), 32'd1);
      chk("redir_instr", id_instr, word(32'h8000_0100));
      chk("redir_pc4", id_pc_plus4, 32'h8000_0104);

      // interrupt beats redirect
      status = 2'b11;
      redirect_valid = 1'b1;
      redirect_target = 32'h8000_0200;
      nx();
      status = 2'b00;
      redirect_valid = 1'b0;
      lat = 1;
      #1;
      chk("intr_flush", 32'(id_valid), 32'd0);
      chk("intr_req", 32'(imem_req), 32'd0);
      chk("intr_pc", imem_addr, 32'h8000_0004);
      nx();
      #1;
      chk("intr_fetch_req", 32'(imem_req), 32'd1);
      chk("intr_fetch_addr", imem_addr, 32'h8000_0004);

      // exception vector
      nx();
      status = 2'b01;
      #1;
      chk("exc_req", 32'(imem_req), 32'd0);
      nx();
      status = 2'b00;
      #1;
      chk("exc_fetch_req", 32'(imem_req), 32'd1);
      chk("exc_fetch_addr", imem_addr, 32'h8000_0008);
      chk("exc_flush", 32'(id_valid), 32'd0);

      // PC increment at the top of the address space
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      nx();
      redirect_valid = 1'b0;
      #1;
      chk("top_req", 32'(imem_req), 32'd1);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      nx();
      #1;
      chk("wrap_addr", imem_addr, WRAP);
      nx();
      #1;
      chk("wrap_valid", 32'(id_valid), 32'd1);
      chk("wrap_pc4", id_pc_plus4, WRAP);
      chk("wrap_instr", id_instr, word(32'hFFFF_FFFC));

      // reset with 3 queued entries and one slow fetch outstanding
      id_ready = 1'b0;
      lat = 1;
      do_reset();
      nx();
      nx();
      nx();
      lat = 3;
      nx();
      #1;
      chk("pre_rst_valid", 32'(id_valid), 32'd1);
      chk("pre_rst_req", 32'(imem_req), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(id_valid), 32'd0);
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_instr", id_instr, 32'd0);
      id_ready = 1'b1;
      lat = 1;
      nx();
      nx();
      rst_n = 1'b1;
      #1;
      chk("refetch_req", 32'(imem_req), 32'd1);
      chk("refetch_addr", imem_addr, 32'h8000_0000);
      nx();
      #1;
      chk("late_ignored", 32'(id_valid), 32'd0);
      nx();
      #1;
      chk("refetch_valid", 32'(id_valid), 32'd1);
      chk("refetch_pc4", id_pc_plus4, 32'h8000_0004);
      chk("refetch_instr", id_instr, word(32'h8000_0000));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupled prefetch queue, replacing the single-register IF/ID latch. It generates the PC, talks to instruction memory over a one-outstanding request/response handshake, and buffers fetched words in a DEPTH-entry FIFO. The ID stage consumes entries with a valid/ready handshake. Branch/jump redirects and interrupt/exception vectoring flush the queue and discard any in-flight fetch.

## Interface
Parameters:
- ADDR_W, 32, PC/address width (≥8)
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_VEC, 32'h8000_0000, PC after reset
- INTR_VEC, 32'h8000_0004, interrupt handler address
- EXC_VEC, 32'h8000_0008, exception handler address

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, combinational
- imem_addr  out  ADDR_W  fetch address, equals current PC
- imem_valid  in  1  response strobe (≥1 cycle after accepted req)
- imem_rdata  in  32  instruction word, valid with imem_valid
- redirect_valid  in  1  taken branch / j / jr this cycle
- redirect_target  in  ADDR_W  new PC for redirect
- status  in  2  {interrupt, exception}
- id_valid  out  1  queue head valid
- id_ready  in  1  ID accepts head
- id_instr  out  32  head instruction
- id_pc_plus4  out  ADDR_W  head PC+4

## Operation
- Per-cycle state: PC, FIFO (rd/wr pointers, count 0..DEPTH), pending (one request outstanding), discard (outstanding response is stale).
- Each entry = {PC_of_fetch + 4, instruction}; tagged at request time.
- pop = id_valid & id_ready. push = imem_valid & ~discard & ~event.
- event = redirect_valid | (|status). Priority: status 2'b10 or 2'b11 → INTR_VEC; 2'b01 → EXC_VEC; else redirect_target.
- imem_req = ~event & (~pending | imem_valid) & (count + pending − pop < DEPTH). An accepted request (imem_req high at the clock edge) advances PC to PC+4 and sets pending.
- On event: PC ← vector/target; FIFO emptied; pop ignored. If pending and no imem_valid this cycle, discard ← 1. Otherwise pending ← 0.
- An imem_valid with discard=1 drops the word, clears discard and pending. A new request may issue in the same cycle.
- Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- PC+4 arithmetic is governed by Configuration.

## Timing
- Reset (async): PC=RESET_VEC, count=0, pending=0, discard=0. Outputs: id_valid=0, id_instr=0, id_pc_plus4=0, imem_req=0 while rst_n low.
- First cycle after reset release: imem_req=1, imem_addr=RESET_VEC.
- Fetch latency: response in cycle N → id_valid=1 in cycle N+1 (registered FIFO).
- With 1-cycle memory, sustained throughput is one instruction per cycle while the queue is not full.
- Full: count+pending=DEPTH with no pop → imem_req=0; PC holds.
- Empty: id_valid=0; id_instr/id_pc_plus4 hold their last values and are don't-care.
- Event: id_valid=0 the cycle after the event; imem_req with the new PC the cycle after the event (or later if a stale response is still pending).
- Reset mid-operation: all state cleared immediately; an in-flight memory response after release must not be pushed (discard is not needed because pending=0; imem_valid with pending=0 is ignored).

## Configuration
- IF_KEEP_KERNEL_BIT_EN defined: PC+4 = {PC[ADDR_W−1], PC[ADDR_W−2:0]+4}, so the MSB (kernel bit) never changes by increment. Applies to both PC advance and entry tags.
- Undefined: PC+4 is a plain ADDR_W-bit add, wrapping modulo 2^ADDR_W.

## Test plan
- Reset, 1-cycle memory, id_ready=1 → fetches 8000_0000, 8000_0004, … ; id_pc_plus4 8000_0004, 8000_0008 back-to-back; first id_valid 2 cycles after release.
- id_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests issued, imem_req low; after id_ready=1, the stream resumes in order with no loss or duplication.
- 3-cycle memory latency; redirect_valid to 8000_0100 while a request is pending → stale word dropped, queue empty; next id_instr comes from 8000_0100.
- status=2'b11 with simultaneous redirect_valid → PC=8000_0004 (interrupt wins); status=2'b01 → 8000_0008.
- PC=FFFF_FFFC → tag and next PC are 8000_0000 with IF_KEEP_KERNEL_BIT_EN, 0000_0000 without.
- rst_n pulsed low while the queue holds 3 entries and one is pending → id_valid=0 immediately; late imem_valid ignored; refetch from RESET_VEC.
